// File: rtl/wb_grf_pkg.sv
// Pipeline defines shared by the writeback stage: writeback source codes,
// the hard-wired zero register index and the link offset for jal/jalr.
package wb_grf_pkg;

  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_DM   = 3'd1,
    WB_PC   = 3'd2,
    WB_EXT  = 3'd3,
    WB_CMP  = 3'd4,
    WB_MD   = 3'd5,
    WB_CP0  = 3'd6,
    WB_NONE = 3'd7
  } wb_sel_e;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [31:0] PC_LINK_OFS = 32'd8;

endpackage

// File: rtl/wb_grf_core.sv
// Raw general register file: registers 1..DEPTH-1, one write port, two
// read ports without bypass. Register 0 is not stored and reads as zero.
module grf_core #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  import wb_grf_pkg::*;

  logic [31:0] regs_q [1:DEPTH-1];

  // NOTE: the architectural state must be cleared on reset, so this memory
  // carries a reset loop and will map to flops rather than a RAM macro.
  // NOTE: non-blocking assignments keep every register update in this block
  // ordered against readers sampling on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we && waddr != REG_ZERO) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/wb_grf.sv
// Writeback stage: picks the result to retire, commits it to the register
// file, bypasses it to the D-stage read ports and publishes a commit record.
module wb_grf #(
  parameter int          DEPTH       = 32,
  parameter logic [31:0] PC_LINK_OFS = wb_grf_pkg::PC_LINK_OFS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC,
  input  logic [4:0]  W_A3,
  input  logic [2:0]  W_WBSel,
  input  logic [31:0] W_ALU_O,
  input  logic [31:0] W_DM_O,
  input  logic [31:0] W_EXT_O,
  input  logic [31:0] W_CMP_O,
  input  logic [31:0] W_MD_O,
  input  logic [31:0] W_CP0_O,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic [31:0] commit_cnt
);
  import wb_grf_pkg::*;

  logic [31:0] raw_rd1;
  logic [31:0] raw_rd2;
  logic [31:0] cnt_q;

  // NOTE: every output of this always_comb gets a default first, so no
  // selector value can leave it unassigned and infer a latch.
  always_comb begin
    wb_data = '0;
    unique case (wb_sel_e'(W_WBSel))
      WB_ALU:  wb_data = W_ALU_O;
      WB_DM:   wb_data = W_DM_O;
      WB_PC:   wb_data = W_PC + PC_LINK_OFS;
      WB_EXT:  wb_data = W_EXT_O;
      WB_CMP:  wb_data = W_CMP_O;
      WB_MD:   wb_data = W_MD_O;
      WB_CP0:  wb_data = W_CP0_O;
      WB_NONE: wb_data = '0;
      default: wb_data = '0;
    endcase
  end

  // Bubbles, stores and $0 targets retire without touching state; reset
  // drops whatever sits in W that cycle.
  assign wb_we   = !reset && (W_WBSel != WB_NONE) && (W_A3 != REG_ZERO);
  assign wb_addr = W_A3;
  assign wb_pc   = W_PC;

  grf_core #(.DEPTH(DEPTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (W_A3),
    .wdata  (wb_data),
    .raddr1 (D_A1),
    .raddr2 (D_A2),
    .rdata1 (raw_rd1),
    .rdata2 (raw_rd2)
  );

  // Write-through: a reader of the register being committed this cycle sees
  // the new value, since the array only updates at the coming edge.
  assign D_RD1 = (D_A1 == REG_ZERO)              ? '0      :
                 (wb_we && D_A1 == W_A3)         ? wb_data : raw_rd1;
  assign D_RD2 = (D_A2 == REG_ZERO)              ? '0      :
                 (wb_we && D_A2 == W_A3)         ? wb_data : raw_rd2;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (wb_we) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: reset, source selection, bypass, suppression,
// mid-stream reset and wrap-around of the link PC and commit counter.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_PC;
  logic [4:0]  W_A3;
  logic [2:0]  W_WBSel;
  logic [31:0] W_ALU_O, W_DM_O, W_EXT_O, W_CMP_O, W_MD_O, W_CP0_O;
  logic [4:0]  D_A1, D_A2;
  logic [31:0] D_RD1, D_RD2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] commit_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  wb_grf dut (
    .clk        (clk),
    .reset      (reset),
    .W_PC       (W_PC),
    .W_A3       (W_A3),
    .W_WBSel    (W_WBSel),
    .W_ALU_O    (W_ALU_O),
    .W_DM_O     (W_DM_O),
    .W_EXT_O    (W_EXT_O),
    .W_CMP_O    (W_CMP_O),
    .W_MD_O     (W_MD_O),
    .W_CP0_O    (W_CP0_O),
    .D_A1       (D_A1),
    .D_A2       (D_A2),
    .D_RD1      (D_RD1),
    .D_RD2      (D_RD2),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_pc      (wb_pc),
    .commit_cnt (commit_cnt)
  );

  task automatic set_sources();
    W_ALU_O = 32'h1111_1111;
    W_DM_O  = 32'h2222_2222;
    W_EXT_O = 32'h4444_4444;
    W_CMP_O = 32'h0000_0001;
    W_MD_O  = 32'h6666_6666;
    W_CP0_O = 32'h7777_7777;
  endtask

  task automatic idle();
    W_WBSel = 3'd7;
    W_A3    = 5'd0;
    W_PC    = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      D_A1 = 5'(a);
      D_A2 = 5'(31 - a);
      #1;
      checks++;
      if (D_RD1 !== 32'h0 || D_RD2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d: rd1=%h rd2=%h want 0", a, D_RD1, D_RD2);
      end
    end
    checks++;
    if (commit_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0", commit_cnt);
    end
    exp_cnt = 32'h0;
  endtask

  task automatic test_source_mux();
    logic [31:0] exp_tab [7];
    exp_tab[0] = 32'h1111_1111;
    exp_tab[1] = 32'h2222_2222;
    exp_tab[2] = 32'h0000_3008;
    exp_tab[3] = 32'h4444_4444;
    exp_tab[4] = 32'h0000_0001;
    exp_tab[5] = 32'h6666_6666;
    exp_tab[6] = 32'h7777_7777;
    set_sources();
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      W_WBSel = 3'(s);
      W_A3    = 5'd5;
      W_PC    = 32'h0000_3000;
      D_A1    = 5'd1;
      D_A2    = 5'd1;
      #1;
      checks++;
      if (wb_we !== 1'b1 || wb_data !== exp_tab[s] || wb_addr !== 5'd5 || wb_pc !== 32'h3000) begin
        errors++;
        $display("FAIL mux_record sel=%0d: we=%b data=%h addr=%0d pc=%h want 1 %h 5 00003000",
                 s, wb_we, wb_data, wb_addr, wb_pc, exp_tab[s]);
      end
      @(posedge clk); #1;
      exp_cnt++;
      idle();
      D_A1 = 5'd5;
      D_A2 = 5'd5;
      #1;
      checks++;
      if (D_RD1 !== exp_tab[s] || D_RD2 !== exp_tab[s]) begin
        errors++;
        $display("FAIL mux_reg5 sel=%0d: rd1=%h rd2=%h want %h", s, D_RD1, D_RD2, exp_tab[s]);
      end
    end
    checks++;
    if (commit_cnt !== 32'd7) begin
      errors++;
      $display("FAIL mux_cnt: got %0d want 7", commit_cnt);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    W_WBSel = 3'd0;
    W_A3    = 5'd9;
    W_ALU_O = 32'hDEAD_BEEF;
    D_A1    = 5'd9;
    D_A2    = 5'd9;
    #1;
    checks++;
    if (D_RD1 !== 32'hDEAD_BEEF || D_RD2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same: rd1=%h rd2=%h want deadbeef", D_RD1, D_RD2);
    end
    @(posedge clk); #1;
    exp_cnt++;
    idle();
    W_ALU_O = 32'h0;
    #1;
    checks++;
    if (D_RD1 !== 32'hDEAD_BEEF || D_RD2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_array: rd1=%h rd2=%h want deadbeef", D_RD1, D_RD2);
    end
  endtask

  task automatic test_suppress();
    @(negedge clk);
    W_WBSel = 3'd0;
    W_A3    = 5'd0;
    W_ALU_O = 32'h0000_1234;
    D_A1    = 5'd0;
    D_A2    = 5'd0;
    #1;
    checks++;
    if (wb_we !== 1'b0 || D_RD1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_dest: we=%b rd1=%h want 0 0", wb_we, D_RD1);
    end
    @(posedge clk); #1;
    checks++;
    if (commit_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL zero_cnt: got %0d want %0d", commit_cnt, exp_cnt);
    end
    W_WBSel = 3'd7;
    W_A3    = 5'd7;
    W_ALU_O = 32'h0000_ABCD;
    D_A1    = 5'd7;
    #1;
    checks++;
    if (wb_we !== 1'b0 || D_RD1 !== 32'h0) begin
      errors++;
      $display("FAIL none_we: we=%b rd1=%h want 0 0", wb_we, D_RD1);
    end
    @(posedge clk); #1;
    idle();
    #1;
    checks++;
    if (D_RD1 !== 32'h0 || commit_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL none_state: rd1=%h cnt=%0d want 0 %0d", D_RD1, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    W_WBSel = 3'd0;
    W_A3    = 5'd3;
    W_ALU_O = 32'h0000_0099;
    @(posedge clk); #1;
    exp_cnt++;
    W_ALU_O = 32'h0000_0055;
    reset   = 1'b1;
    D_A1    = 5'd3;
    #1;
    checks++;
    if (wb_we !== 1'b0 || D_RD1 !== 32'h0000_0099) begin
      errors++;
      $display("FAIL reset_mid_comb: we=%b rd1=%h want 0 00000099", wb_we, D_RD1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    #1;
    exp_cnt = 32'h0;
    checks++;
    if (D_RD1 !== 32'h0 || commit_cnt !== 32'h0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: rd1=%h cnt=%h we=%b want 0 0 0", D_RD1, commit_cnt, wb_we);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    W_WBSel = 3'd2;
    W_A3    = 5'd10;
    W_PC    = 32'hFFFF_FFFC;
    D_A1    = 5'd10;
    D_A2    = 5'd0;
    #1;
    checks++;
    if (wb_data !== 32'h0000_0004 || D_RD1 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL pc_wrap: data=%h rd1=%h want 00000004", wb_data, D_RD1);
    end
    @(posedge clk); #1;
    exp_cnt++;
    idle();
    #1;
    checks++;
    if (D_RD1 !== 32'h0000_0004 || commit_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL pc_wrap_reg: rd1=%h cnt=%0d want 00000004 %0d", D_RD1, commit_cnt, exp_cnt);
    end
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    checks++;
    if (commit_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL cnt_preload: got %h want ffffffff", commit_cnt);
    end
    @(negedge clk);
    W_WBSel = 3'd0;
    W_A3    = 5'd11;
    W_ALU_O = 32'h0BAD_F00D;
    @(posedge clk); #1;
    idle();
    #1;
    checks++;
    if (commit_cnt !== 32'h0) begin
      errors++;
      $display("FAIL cnt_wrap: got %h want 0", commit_cnt);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_sources();
    D_A1 = 5'd0;
    D_A2 = 5'd0;
    exp_cnt = 32'h0;
    test_reset();
    test_source_mux();
    test_bypass();
    test_suppress();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
